// File: rtl/npu_buf_pkg.sv
// rtl/npu_buf_pkg.sv - shared constants for the NPU output-buffer address path
//
// Purpose: default geometry of RAM_O and the systolic array, and the FSM state
// encoding used by skewed_addr_gen_o.
package npu_buf_pkg;

  localparam int DEF_RAM_O_SIZE = 256;
  localparam int DEF_ARRAY_M    = 8;
  localparam int DEF_ADDR_WIDTH = $clog2(DEF_RAM_O_SIZE);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/addr_skew_line.sv
// rtl/addr_skew_line.sv - per-column delay line fanning column 0 out to all columns
//
// Purpose: shift register of ARRAY_M-1 {valid, addr} stages. Stage m holds the
// column-0 stream delayed by m cycles and drives column m when skewing; when
// aligned every column takes column 0 directly. Lanes >= num_cols are masked.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   clear           empties the line (new command accepted)
//   in_valid/addr   column-0 stream (already registered)
//   skew_en         1 = column m uses stage m, 0 = all columns use column 0
//   num_cols        active column count (already clamped)
//   addr_set        packed per-column addresses, 0 when not enabled
//   enable_set      per-column write enables
module addr_skew_line
  import npu_buf_pkg::*;
#(
  parameter int ARRAY_M    = DEF_ARRAY_M,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int COL_W      = $clog2(ARRAY_M) + 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clear,
  input  logic                          in_valid,
  input  logic [ADDR_WIDTH-1:0]         in_addr,
  input  logic                          skew_en,
  input  logic [COL_W-1:0]              num_cols,
  output logic [ADDR_WIDTH*ARRAY_M-1:0] addr_set,
  output logic [ARRAY_M-1:0]            enable_set
);

  logic [ARRAY_M-1:1]    stage_valid_d, stage_valid_q;
  logic [ADDR_WIDTH-1:0] stage_addr_d [1:ARRAY_M-1];
  logic [ADDR_WIDTH-1:0] stage_addr_q [1:ARRAY_M-1];

  always_comb begin
    stage_valid_d = stage_valid_q;
    stage_addr_d  = stage_addr_q;
    if (clear) begin
      // Stale tail of a previous command must not leak into wider columns.
      stage_valid_d = '0;
      for (int j = 1; j < ARRAY_M; j++) stage_addr_d[j] = '0;
    end else begin
      stage_valid_d[1] = in_valid;
      stage_addr_d[1]  = in_addr;
      for (int j = 2; j < ARRAY_M; j++) begin
        stage_valid_d[j] = stage_valid_q[j-1];
        stage_addr_d[j]  = stage_addr_q[j-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stage_valid_q <= '0;
      for (int j = 1; j < ARRAY_M; j++) stage_addr_q[j] <= '0;
    end else begin
      stage_valid_q <= stage_valid_d;
      for (int j = 1; j < ARRAY_M; j++) stage_addr_q[j] <= stage_addr_d[j];
    end
  end

  for (genvar m = 0; m < ARRAY_M; m++) begin : g_lane
    logic                  lane_valid;
    logic [ADDR_WIDTH-1:0] lane_addr;
    if (m == 0) begin : g_head
      assign lane_valid = in_valid;
      assign lane_addr  = in_addr;
    end else begin : g_tap
      assign lane_valid = skew_en ? stage_valid_q[m] : in_valid;
      assign lane_addr  = skew_en ? stage_addr_q[m]  : in_addr;
    end
    assign enable_set[m] = lane_valid && (COL_W'(m) < num_cols);
    assign addr_set[ADDR_WIDTH*m +: ADDR_WIDTH] = enable_set[m] ? lane_addr : '0;
  end

endmodule

// File: rtl/skewed_addr_gen_o.sv
// rtl/skewed_addr_gen_o.sv - bounded, optionally skewed RAM_O write address generator
//
// Purpose: on a start pulse in IDLE, issues num_rows addresses base + r*stride
// (mod 2^ADDR_WIDTH) on column 0 starting the next cycle, replicated to every
// active column either aligned or delayed m cycles for column m.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   start        command pulse, honoured only in IDLE
//   skew_en      column m lags column 0 by m cycles when 1
//   num_cols     active columns, clamped to ARRAY_M
//   num_rows     rows per command, 0..RAM_O_SIZE
//   base_addr    first row address
//   stride       per-row address increment
//   addr_set     packed per-column addresses
//   enable_set   per-column write enables
//   busy         command in progress
//   done         one-cycle completion pulse
module skewed_addr_gen_o
  import npu_buf_pkg::*;
#(
  parameter int RAM_O_SIZE     = DEF_RAM_O_SIZE,
  parameter int ARRAY_M        = DEF_ARRAY_M,
  parameter int ADDR_WIDTH     = $clog2(RAM_O_SIZE),
  parameter int ADDR_SET_WIDTH = ADDR_WIDTH * ARRAY_M
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         skew_en,
  input  logic [$clog2(ARRAY_M):0]     num_cols,
  input  logic [ADDR_WIDTH:0]          num_rows,
  input  logic [ADDR_WIDTH-1:0]        base_addr,
  input  logic [ADDR_WIDTH-1:0]        stride,
  output logic [ADDR_SET_WIDTH-1:0]    addr_set,
  output logic [ARRAY_M-1:0]           enable_set,
  output logic                         busy,
  output logic                         done
);

  localparam int COL_W = $clog2(ARRAY_M) + 1;
  localparam int ROW_W = ADDR_WIDTH + 1;

  logic [1:0]            state_d, state_q;
  logic [COL_W-1:0]      cols_d, cols_q;
  logic                  skew_d, skew_q;
  logic [ADDR_WIDTH-1:0] stride_d, stride_q;
  logic [ADDR_WIDTH-1:0] acc_d, acc_q;
  logic [ROW_W-1:0]      rows_left_d, rows_left_q;
  logic [COL_W-1:0]      drain_d, drain_q;
  logic                  v0_d, v0_q;
  logic [ADDR_WIDTH-1:0] a0_d, a0_q;
  logic                  clear_line;
  logic [COL_W-1:0]      cols_clamped;

  assign cols_clamped = (num_cols > COL_W'(ARRAY_M)) ? COL_W'(ARRAY_M) : num_cols;

  always_comb begin
    state_d     = state_q;
    cols_d      = cols_q;
    skew_d      = skew_q;
    stride_d    = stride_q;
    acc_d       = acc_q;
    rows_left_d = rows_left_q;
    drain_d     = drain_q;
    v0_d        = 1'b0;
    a0_d        = '0;
    clear_line  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          clear_line = 1'b1;
          cols_d     = cols_clamped;
          skew_d     = skew_en;
          stride_d   = stride;
          if (cols_clamped == '0 || num_rows == '0) begin
            state_d = ST_DONE;
          end else begin
            // Row 0 is issued straight from the command inputs; the
            // accumulator then always holds the next row's address.
            state_d     = ST_RUN;
            v0_d        = 1'b1;
            a0_d        = base_addr;
            acc_d       = base_addr + stride;
            rows_left_d = num_rows - ROW_W'(1);
          end
        end
      end
      ST_RUN: begin
        if (rows_left_q != '0) begin
          v0_d        = 1'b1;
          a0_d        = acc_q;
          acc_d       = acc_q + stride_q;
          rows_left_d = rows_left_q - ROW_W'(1);
        end else if (skew_q && cols_q > COL_W'(1)) begin
          // Skew depth S = cols-1 extra cycles; count S-1 down to 0.
          state_d = ST_DRAIN;
          drain_d = cols_q - COL_W'(2);
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DRAIN: begin
        if (drain_q == '0) state_d = ST_DONE;
        else               drain_d = drain_q - COL_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cols_q      <= '0;
      skew_q      <= 1'b0;
      stride_q    <= '0;
      acc_q       <= '0;
      rows_left_q <= '0;
      drain_q     <= '0;
      v0_q        <= 1'b0;
      a0_q        <= '0;
    end else begin
      state_q     <= state_d;
      cols_q      <= cols_d;
      skew_q      <= skew_d;
      stride_q    <= stride_d;
      acc_q       <= acc_d;
      rows_left_q <= rows_left_d;
      drain_q     <= drain_d;
      v0_q        <= v0_d;
      a0_q        <= a0_d;
    end
  end

  assign busy = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done = (state_q == ST_DONE);

  addr_skew_line #(
    .ARRAY_M    (ARRAY_M),
    .ADDR_WIDTH (ADDR_WIDTH),
    .COL_W      (COL_W)
  ) u_skew_line (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear_line),
    .in_valid   (v0_q),
    .in_addr    (a0_q),
    .skew_en    (skew_q),
    .num_cols   (cols_q),
    .addr_set   (addr_set),
    .enable_set (enable_set)
  );

endmodule

// File: tb/tb_skewed_addr_gen_o.sv
// tb/tb_skewed_addr_gen_o.sv - self-checking bench for skewed_addr_gen_o
module tb_skewed_addr_gen_o;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        skew_en;
  logic [3:0]  num_cols;
  logic [8:0]  num_rows;
  logic [7:0]  base_addr;
  logic [7:0]  stride;
  logic [63:0] addr_set;
  logic [7:0]  enable_set;
  logic        busy;
  logic        done;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  skewed_addr_gen_o dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .skew_en    (skew_en),
    .num_cols   (num_cols),
    .num_rows   (num_rows),
    .base_addr  (base_addr),
    .stride     (stride),
    .addr_set   (addr_set),
    .enable_set (enable_set),
    .busy       (busy),
    .done       (done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected outputs in cycle k after the command was sampled (cycle 0).
  task automatic check_cycle(input string tag, input int k, input bit sk, input int nc,
                             input int nr, input int ba, input int st);
    int c, s, d;
    bit degen;
    logic [63:0] e_addr;
    logic [7:0]  e_en;
    c = (nc > 8) ? 8 : nc;
    degen = (c == 0) || (nr == 0);
    s = sk ? c - 1 : 0;
    e_addr = '0;
    e_en = '0;
    for (int m = 0; m < 8; m++) begin
      d = sk ? m : 0;
      if (!degen && m < c && k >= 1 + d && k <= nr + d) begin
        e_en[m] = 1'b1;
        e_addr[8*m +: 8] = 8'((ba + (k - 1 - d) * st) % 256);
      end
    end
    chk($sformatf("%s k=%0d enable_set", tag, k), {56'd0, enable_set}, {56'd0, e_en});
    chk($sformatf("%s k=%0d addr_set", tag, k), addr_set, e_addr);
    chk($sformatf("%s k=%0d busy", tag, k), {63'd0, busy},
        {63'd0, (!degen && k >= 1 && k <= nr + s)});
    chk($sformatf("%s k=%0d done", tag, k), {63'd0, done},
        {63'd0, (degen ? (k == 1) : (k == nr + s + 1))});
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, " enable_set"}, {56'd0, enable_set}, 64'd0);
    chk({tag, " addr_set"}, addr_set, 64'd0);
    chk({tag, " busy"}, {63'd0, busy}, 64'd0);
    chk({tag, " done"}, {63'd0, done}, 64'd0);
  endtask

  // Random input churn while busy/done: none of it may alter the command.
  task automatic scramble();
    start     = ($urandom_range(0, 2) == 0);
    skew_en   = 1'($urandom_range(0, 1));
    num_cols  = 4'($urandom_range(0, 15));
    num_rows  = 9'($urandom_range(0, 256));
    base_addr = 8'($urandom_range(0, 255));
    stride    = 8'($urandom_range(0, 255));
  endtask

  task automatic run_cmd(input string tag, input bit sk, input int nc, input int nr,
                         input int ba, input int st);
    int c, last;
    @(negedge clk);
    start     = 1'b1;
    skew_en   = sk;
    num_cols  = 4'(nc);
    num_rows  = 9'(nr);
    base_addr = 8'(ba);
    stride    = 8'(st);
    c = (nc > 8) ? 8 : nc;
    last = (c == 0 || nr == 0) ? 1 : nr + (sk ? c - 1 : 0) + 1;
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      check_cycle(tag, k, sk, nc, nr, ba, st);
      scramble();
    end
  endtask

  task automatic idle_cycles(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start = 1'b0;
      check_quiet($sformatf("%s idle%0d", tag, i));
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    skew_en = 1'b0;
    num_cols = '0;
    num_rows = '0;
    base_addr = '0;
    stride = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_quiet("reset");
    reset = 1'b0;
    idle_cycles("post_reset", 2);

    run_cmd("aligned", 1'b0, 8, 4, 'h10, 1);
    run_cmd("skew_partial", 1'b1, 3, 2, 'h20, 4);
    run_cmd("wrap", 1'b0, 1, 3, 'hFE, 3);
    run_cmd("rows0", 1'b1, 8, 0, 'h33, 5);
    run_cmd("cols0", 1'b0, 0, 5, 'h44, 2);
    run_cmd("clamp15", 1'b1, 15, 3, 'h80, 'h11);
    run_cmd("narrow_after_wide", 1'b1, 8, 1, 'h05, 'h07);
    run_cmd("rows256", 1'b0, 2, 256, 'h00, 1);
    idle_cycles("gap", 2);

    // Reset in cycle 2 of a skewed 8-column, 4-row command.
    @(negedge clk);
    start = 1'b1; skew_en = 1'b1; num_cols = 4'd8; num_rows = 9'd4;
    base_addr = 8'h40; stride = 8'h02;
    @(negedge clk);
    check_cycle("pre_reset", 1, 1'b1, 8, 4, 'h40, 2);
    start = 1'b0;
    @(negedge clk);
    check_cycle("pre_reset", 2, 1'b1, 8, 4, 'h40, 2);
    reset = 1'b1;
    @(negedge clk);
    check_quiet("in_reset");
    reset = 1'b0;
    idle_cycles("after_reset", 12);

    for (int i = 0; i < 30; i++) begin
      int nr;
      nr = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 12);
      run_cmd($sformatf("rand%0d", i), 1'($urandom_range(0, 1)), $urandom_range(0, 15),
              nr, $urandom_range(0, 255), $urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) idle_cycles($sformatf("rgap%0d", i), $urandom_range(1, 3));
    end
    idle_cycles("final", 10);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/skewed_addr_gen_o.md
# skewed_addr_gen_o

Output-buffer address generator for the NPU systolic array. It is started by a one-cycle command and emits one RAM_O address per active column for `num_rows` consecutive rows. Addresses follow `base_addr + row*stride` with wrap-around. An optional per-column diagonal skew matches the systolic output drain. It sits between the NPU controller and the banked RAM_O write ports and replaces free-running output address counting with a bounded, handshaked sequence.

## Interface
- `RAM_O_SIZE`, 256: words per RAM_O bank.
- `ARRAY_M`, 8: number of array columns, which is also the number of address channels.
- `ADDR_WIDTH`, `$clog2(RAM_O_SIZE)`: width of one address.
- `ADDR_SET_WIDTH`, `ADDR_WIDTH*ARRAY_M`: width of the packed address bus.

Ports (reset: reset, synchronous, active-high; clock: clk):
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high; clears all state.
- `start`  in  1  command pulse; accepted only when idle.
- `skew_en`  in  1  1 = column m lags column 0 by m cycles; 0 = all columns aligned.
- `num_cols`  in  `$clog2(ARRAY_M)+1`  active column count; values above ARRAY_M are clamped to ARRAY_M.
- `num_rows`  in  `ADDR_WIDTH+1`  rows per command, 0..RAM_O_SIZE.
- `base_addr`  in  `ADDR_WIDTH`  first address.
- `stride`  in  `ADDR_WIDTH`  address increment per row.
- `addr_set`  out  `ADDR_SET_WIDTH`  column m address in bits `[ADDR_WIDTH*m +: ADDR_WIDTH]`.
- `enable_set`  out  `ARRAY_M`  per-column write enable.
- `busy`  out  1  command in progress.
- `done`  out  1  one-cycle completion pulse.

## Operation
- FSM states:
  - IDLE → RUN on `start`, when the clamped `num_cols`≠0 and `num_rows`≠0.
  - IDLE → DONE on `start` with zero rows or zero columns. No enable is issued.
  - RUN → DRAIN after column 0 issues its last row. When S=0 (see below), RUN → DONE directly.
  - DRAIN → DONE once the last active column issues its last row.
  - DONE → IDLE unconditionally. The FSM is in DONE for exactly one cycle.
- On command acceptance, `num_cols` (clamped), `num_rows`, `base_addr`, `stride` and `skew_en` are latched. Input changes during busy have no effect.
- Row address: `base + r*stride` mod 2^ADDR_WIDTH, computed as a running sum (no multiplier). Wraps silently.
- Column m < active cols emits the same row sequence as column 0, delayed m cycles when `skew_en`=1, undelayed otherwise.
- Columns m ≥ active cols: enable always 0 and address held 0.
- S = skew depth = `skew_en` ? active_cols−1 : 0.
- `start` while busy or in DONE is ignored, with no queueing. `start` in the first IDLE cycle after DONE is accepted.

## Timing
- Cycle 0 is the cycle `start` is sampled high in IDLE. Output latency is one cycle.
- Column 0: `enable_set[0]`=1 in cycles 1..N, where N=`num_rows`. Its address in cycle k is `base+(k−1)*stride`.
- Column m (skewed): enabled in cycles 1+m..N+m with the same address sequence shifted by m.
- `busy`=1 in cycles 1..N+S.
- `done`=1 in cycle N+S+1 only. For a zero-row or zero-column command, `done`=1 in cycle 1 and `busy` stays 0.
- Addresses are registered and valid only when the matching enable is 1. Otherwise they hold 0.
- Reset values: `addr_set`=0, `enable_set`=0, `busy`=0, `done`=0, FSM=IDLE, delay line cleared.
- Reset mid-command: takes effect on the next edge. All enables drop, no `done` is issued, and no residual skewed writes occur afterwards.

## Structure
- Shared package `npu_buf_pkg`:
  - FSM state encoding (IDLE/RUN/DRAIN/DONE).
  - `ADDR_WIDTH`-derived helper constants.
- Sub-module `addr_skew_line`: an ARRAY_M−1 stage shift register of {valid, addr}.
  - Tap m feeds column m when skewed; it is bypassed when aligned.
  - Lanes ≥ active cols are masked.
- Top level holds the FSM, row counter, running address accumulator and output registers. Target size is about 200 lines.

## Test plan
- Aligned: `skew_en`=0, cols=8, rows=4, base=0x10, stride=1 → all 8 enables high in cycles 1–4 with addr 0x10,0x11,0x12,0x13; `done` in cycle 5.
- Skewed partial: `skew_en`=1, cols=3, rows=2, base=0x20, stride=4 → col0 addrs 0x20,0x24 in cycles 1–2; col1 in cycles 2–3; col2 in cycles 3–4; cols 3–7 never enabled; `done` in cycle 5.
- Wrap: base=0xFE, stride=3, rows=3 (RAM_O_SIZE=256) → addrs 0xFE,0x01,0x04.
- Degenerate and clamp:
  - rows=0 → `done` in cycle 1, no enables.
  - cols=15 → clamped to 8.
- Back-to-back:
  - `start` asserted during busy → ignored.
  - `start` in the cycle right after `done` → accepted; new column 0 sequence starts the next cycle.
- Reset in cycle 2 of a skewed 8-column, 4-row command → all outputs 0 from the next cycle; no later enables and no `done`.
